imem_loader: RTL and testbench

- Program loader that writes the instruction memory through its byte-addressable write port (write_enable, write_addr, write_data).
- Receives a framed byte stream from the host/UART side over a valid/ready handshake, assembles little-endian 32-bit words and issues one memory write per word.
- Holds the CPU in reset until a load completes with a good checksum.

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (SYNC, LEN_LO, LEN_HI, payload, CSUM),
// packs little-endian 32-bit words into instruction memory and releases the CPU
// from reset only after a frame with a matching XOR checksum has been loaded.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_BYTES = 1024,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        abort,
    output logic        write_enable,
    output logic [31:0] write_addr,
    output logic [31:0] write_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    // Largest word count that still fits in the instruction memory.
    localparam logic [15:0] MAX_WORDS = 16'(MEM_BYTES / 4);

    state_t      state;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [7:0]  acc;
    logic [23:0] partial;

    logic        take;
    logic [15:0] len_now;

    assign take    = in_valid && in_ready;
    assign len_now = {in_data, len[7:0]};

    // Frame FSM: byte capture, word assembly, memory write strobe and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            in_ready      <= 1'b0;
            write_enable  <= 1'b0;
            write_addr    <= BASE_ADDR;
            write_data    <= 32'h0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= 16'h0;
            len           <= 16'h0;
            byte_idx      <= 2'd0;
            acc           <= 8'h0;
            partial       <= 24'h0;
        end else begin
            in_ready     <= 1'b1;
            write_enable <= 1'b0;
            if (abort && state != DONE) begin
                // Abort wins over a simultaneous byte, so a word completed by
                // that byte is never written.
                state    <= IDLE;
                cpu_hold <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
            end else if (take) begin
                case (state)
                    IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            state         <= LEN0;
                            words_written <= 16'h0;
                            byte_idx      <= 2'd0;
                            acc           <= 8'h0;
                        end
                    end
                    LEN0: begin
                        len[7:0] <= in_data;
                        state    <= LEN1;
                    end
                    LEN1: begin
                        len[15:8] <= in_data;
                        if (len_now > MAX_WORDS) begin
                            state    <= ERR;
                            error    <= 1'b1;
                            cpu_hold <= 1'b1;
                            done     <= 1'b0;
                        end else if (len_now == 16'h0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        acc      <= acc ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: partial[7:0]   <= in_data;
                            2'd1: partial[15:8]  <= in_data;
                            2'd2: partial[23:16] <= in_data;
                            default: begin
                                // Fourth byte: the word is written on the next cycle.
                                write_enable  <= 1'b1;
                                write_data    <= {in_data, partial};
                                write_addr    <= BASE_ADDR + {14'h0, words_written, 2'b00};
                                words_written <= words_written + 16'd1;
                                if (words_written + 16'd1 == len) begin
                                    state <= CSUM;
                                end
                            end
                        endcase
                    end
                    CSUM: begin
                        if (in_data == acc) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                            error    <= 1'b0;
                        end else begin
                            state    <= ERR;
                            error    <= 1'b1;
                            cpu_hold <= 1'b1;
                            done     <= 1'b0;
                        end
                    end
                    DONE, ERR: begin
                        if (in_data == SYNC_BYTE) begin
                            state         <= LEN0;
                            words_written <= 16'h0;
                            byte_idx      <= 2'd0;
                            acc           <= 8'h0;
                            cpu_hold      <= 1'b1;
                            done          <= 1'b0;
                            error         <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: frames are built from word lists, expected memory
// writes are queued by the stimulus and consumed by an independent write monitor.
module tb_imem_loader;

    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam int          MEM_BYTES = 1024;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        abort;
    logic        write_enable;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] exp_q[$];     // {addr, data} of each write the model predicts
    logic [31:0] payload[$];   // words of the next frame
    logic [63:0] mon_e;

    imem_loader #(
        .BASE_ADDR(BASE),
        .MEM_BYTES(MEM_BYTES),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .abort(abort),
        .write_enable(write_enable),
        .write_addr(write_addr),
        .write_data(write_data),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .words_written(words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (reset === 1'b1 && write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got addr %h data %h required no write",
                         write_addr, write_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", write_addr, mon_e[63:32]);
                check("write_data", write_data, mon_e[31:0]);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_status(input string tag, input bit exp_done, input int exp_ww);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_error"}, 32'(error), 32'(!exp_done));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
        check({tag, "_words_written"}, 32'(words_written), 32'(exp_ww));
    endtask

    // Sends a whole frame of 'len' words taken from payload; the model decides
    // which writes must appear and how the frame must end.
    task automatic run_frame(input string tag, input int len, input bit good, input bit gaps);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [15:0] l16;
        logic [31:0] w;
        bit          ok_len;
        x      = 8'h0;
        l16    = 16'(len);
        ok_len = (len <= MEM_BYTES / 4);
        send(8'hA5);
        send(l16[7:0]);
        send(l16[15:8]);
        if (ok_len) begin
            for (int i = 0; i < len; i++) begin
                w = payload[i];
                exp_q.push_back({BASE + 32'(4 * i), w});
                for (int k = 0; k < 4; k++) begin
                    b = w[8*k +: 8];
                    x = x ^ b;
                    if (gaps && $urandom_range(0, 3) == 0) idle(1);
                    send(b);
                end
            end
            send(good ? x : (x ^ 8'(1 + $urandom_range(0, 254))));
        end
        idle(3);
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        check_status(tag, ok_len && good, ok_len ? len : 0);
    endtask

    task automatic fill_random(input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h0;
        abort    = 1'b0;
        #1 reset = 1'b0;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_write_enable", 32'(write_enable), 32'd0);
        check("rst_write_addr", write_addr, BASE);
        check("rst_write_data", write_data, 32'h0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words_written", 32'(words_written), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle(2);
        check("in_ready_after_reset", 32'(in_ready), 32'd1);

        // Noise in IDLE, then an empty frame.
        send(8'h00); send(8'hFF); send(8'h5A);
        idle(2);
        check("noise_no_done", 32'(done), 32'd0);
        payload.delete();
        run_frame("zero_len", 0, 1'b1, 1'b0);

        // Abort is ignored once the load is done.
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        idle(1);
        check("abort_in_done_done", 32'(done), 32'd1);
        check("abort_in_done_cpu_hold", 32'(cpu_hold), 32'd0);

        // Nominal two-word frame.
        payload.delete();
        payload.push_back(32'h0000_0513);
        payload.push_back(32'h0010_0093);
        run_frame("nominal", 2, 1'b1, 1'b0);

        // Same frame with a bad checksum, then SYNC clears the error.
        run_frame("bad_csum", 2, 1'b0, 1'b0);
        send(8'hA5);
        idle(1);
        check("resync_error", 32'(error), 32'd0);
        check("resync_cpu_hold", 32'(cpu_hold), 32'd1);
        check("resync_done", 32'(done), 32'd0);
        send(8'h00); send(8'h00); send(8'h00);
        idle(2);
        check_status("resync_zero", 1'b1, 0);

        // Length limit: 257 words rejected, 256 accepted.
        run_frame("len257", 257, 1'b1, 1'b0);
        fill_random(256);
        run_frame("len256", 256, 1'b1, 1'b0);

        // Abort after two payload bytes: back in IDLE, so later bytes write nothing.
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22);
        abort = 1'b1;
        idle(1);
        abort = 1'b0;
        check("abort_mid_cpu_hold", 32'(cpu_hold), 32'd1);
        check("abort_mid_done", 32'(done), 32'd0);
        check("abort_mid_error", 32'(error), 32'd0);
        send(8'h33); send(8'h44); send(8'h55); send(8'h66);
        idle(3);

        // Abort coinciding with the 4th byte cancels that word's write.
        send(8'hA5); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        abort = 1'b1;
        send(8'h44);
        abort = 1'b0;
        idle(3);
        check("abort_4th_words_written", 32'(words_written), 32'd0);
        check("abort_4th_cpu_hold", 32'(cpu_hold), 32'd1);

        // Back-to-back streaming of a 4-word frame.
        fill_random(4);
        run_frame("stream4", 4, 1'b1, 1'b0);

        // Random frames with random gaps and checksum quality.
        for (int f = 0; f < 10; f++) begin
            int  len;
            bit  good;
            len  = ($urandom_range(0, 7) == 0) ? 300 : int'($urandom_range(0, 8));
            good = ($urandom_range(0, 3) != 0);
            fill_random(len);
            run_frame("random", len, good, 1'b1);
        end

        // Reset mid-word: two words written, then two bytes of a third.
        fill_random(3);
        send(8'hA5); send(8'h03); send(8'h00);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({BASE + 32'(4 * i), payload[i]});
            for (int k = 0; k < 4; k++) send(payload[i][8*k +: 8]);
        end
        send(payload[2][7:0]); send(payload[2][15:8]);
        idle(1);
        check("pre_reset_words_written", 32'(words_written), 32'd2);
        #3 reset = 1'b0;
        #1;
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        check("async_rst_write_addr", write_addr, BASE);
        check("async_rst_write_data", write_data, 32'h0);
        check("async_rst_words_written", 32'(words_written), 32'd0);
        check("async_rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("async_rst_pending", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        idle(2);
        fill_random(2);
        run_frame("after_reset", 2, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
